// File: rtl/simon_pkg.sv
// simon_pkg: shared SIMON64/128 constants, state type and rotate helpers.
package simon_pkg;
  localparam int SIMON_WORD = 32;
  localparam int SIMON_ROUNDS = 44;
  localparam int SIMON_KEYWORDS = 4;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [SIMON_WORD-1:0] SIMON_C = 32'hFFFFFFFC;
  typedef enum logic {IDLE, EXPAND} state_t;
  function automatic logic [SIMON_WORD-1:0] ror(input logic [SIMON_WORD-1:0] x, input int r);
    return (x >> r) | (x << (SIMON_WORD - r));
  endfunction
  function automatic logic [SIMON_WORD-1:0] rol(input logic [SIMON_WORD-1:0] x, input int r);
    return (x << r) | (x >> (SIMON_WORD - r));
  endfunction
endpackage

// File: rtl/simon_key_schedule_if.sv
// simon_key_schedule_if: key load/status and round-key read port bundle.
interface simon_key_schedule_if;
  logic key_load;
  logic [4*simon_pkg::SIMON_WORD-1:0] key_in;
  logic busy;
  logic done;
  logic key_valid;
  logic [5:0] rk_rd_idx;
  logic [simon_pkg::SIMON_WORD-1:0] rk_rd_data;
  modport master(output key_load, key_in, rk_rd_idx, input busy, done, key_valid, rk_rd_data);
  modport slave(input key_load, key_in, rk_rd_idx, output busy, done, key_valid, rk_rd_data);
endinterface

// File: rtl/simon_key_step.sv
// simon_key_step: combinational SIMON64/128 next-round-key function.
module simon_key_step
  import simon_pkg::*;
(
  input  logic [SIMON_WORD-1:0] w0,
  input  logic [SIMON_WORD-1:0] w1,
  input  logic [SIMON_WORD-1:0] w3,
  input  logic                  z,
  output logic [SIMON_WORD-1:0] knew
);
  logic [SIMON_WORD-1:0] tmp;
  assign tmp = ror(w3, 3) ^ w1;
  // SIMON_C ^ w0 is the same as ~w0 ^ 3
  assign knew = SIMON_C ^ w0 ^ tmp ^ ror(tmp, 1) ^ {{(SIMON_WORD-1){1'b0}}, z};
endmodule

// File: rtl/simon_key_schedule.sv
// simon_key_schedule: iterative SIMON64/128 key expansion into a 44x32 register file,
// one round key per clock, with a registered read-back port.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int WORD = SIMON_WORD,
  parameter int ROUNDS = SIMON_ROUNDS,
  parameter int KEYWORDS = SIMON_KEYWORDS
) (
  input logic clk,
  input logic rst_n,
  simon_key_schedule_if.slave kif
);
  state_t state;
  logic [5:0] i;
  logic [5:0] zi;
  logic [WORD-1:0] w [KEYWORDS];
  logic [WORD-1:0] mem [ROUNDS];
  logic [WORD-1:0] knew;
  assign zi = 6'd61 - i;
  simon_key_step u_step (.w0(w[0]), .w1(w[1]), .w3(w[3]), .z(Z3[zi]), .knew(knew));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i <= '0;
      kif.busy <= 1'b0;
      kif.done <= 1'b0;
      kif.key_valid <= 1'b0;
      kif.rk_rd_data <= '0;
    end else begin
      kif.done <= 1'b0;
      if (kif.key_load) begin
        state <= EXPAND;
        i <= '0;
        kif.busy <= 1'b1;
        kif.key_valid <= 1'b0;
      end else if (state == EXPAND) begin
        i <= i + 6'd1;
        if (i == 6'(ROUNDS - KEYWORDS - 1)) begin
          state <= IDLE;
          kif.busy <= 1'b0;
          kif.done <= 1'b1;
          kif.key_valid <= 1'b1;
        end
      end
      kif.rk_rd_data <= (kif.rk_rd_idx < 6'(ROUNDS)) ? mem[kif.rk_rd_idx] : '0;
    end
  end
  // Key storage and shift window carry no reset; key_valid guards their meaning.
  always_ff @(posedge clk) begin
    if (kif.key_load) begin
      for (int k = 0; k < KEYWORDS; k++) begin
        mem[k] <= kif.key_in[k*WORD +: WORD];
        w[k] <= kif.key_in[k*WORD +: WORD];
      end
    end else if (state == EXPAND) begin
      mem[i + 6'd4] <= knew;
      w[0] <= w[1];
      w[1] <= w[2];
      w[2] <= w[3];
      w[3] <= knew;
    end
  end
endmodule
